// File: rtl/dsp_mult_arbiter.sv
// dsp_mult_arbiter
//   Round-robin arbiter that time-shares one DSP48E1 signed multiplier
//   (AREG=BREG=MREG=PREG=1, OPMODEREG=1) between NUM_REQ requesters. Each
//   transfer loads the DSP operand registers and pushes a requester tag into
//   a shift register that runs in step with the DSP pipeline, so the product
//   leaving P can be returned with its requester ID.
//
//   Optional feature: define DSP_ARB_ACC_EN to enable accumulate bursts.
//   A burst locks the grant to one requester, uses P=P+M after the first
//   beat and returns only the final accumulated value.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_a / req_b       packed signed operands, 25 / 18 bits per requester
//   req_acc / req_last  accumulate-burst controls (DSP_ARB_ACC_EN only)
//   dsp_*               DSP48E1 operand/control outputs, dsp_p product input
//   rsp_valid/id/data   one-cycle tagged product
//   busy                any issued operation still in flight
module dsp_mult_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DSP_LAT = 3,
    parameter int ID_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*25-1:0]  req_a,
    input  logic [NUM_REQ*18-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_acc,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [29:0]            dsp_a,
    output logic [17:0]            dsp_b,
    output logic [6:0]             dsp_opmode,
    output logic [3:0]             dsp_alumode,
    output logic [4:0]             dsp_inmode,
    output logic                   dsp_ce,
    input  logic [47:0]            dsp_p,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [47:0]            rsp_data,
    output logic                   busy
);

    localparam logic [6:0] OP_IDLE = 7'b0000000;  // P = 0
    localparam logic [6:0] OP_MUL  = 7'b0000101;  // P = M
    localparam logic [6:0] OP_MAC  = 7'b0100101;  // P = P + M
    localparam logic [6:0] OP_HOLD = 7'b0100000;  // P = P (idle inside a burst)

    logic                      ce_q;
    logic [ID_W-1:0]           ptr_q, ptr_d;
    logic [29:0]               dsp_a_q, dsp_a_d;
    logic [17:0]               dsp_b_q, dsp_b_d;
    logic [6:0]                op_iss_q, op_iss_d;
    logic [6:0]                dsp_opmode_q;
    // Slot 0 lines up with dsp_a/dsp_b; slot DSP_LAT lines up with valid dsp_p.
    logic [DSP_LAT:0]            vld_pipe_q, vld_pipe_d;
    logic [DSP_LAT:0][ID_W-1:0]  id_pipe_q, id_pipe_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
    logic [47:0]               rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]        elig;
    logic                      hi_vld, lo_vld, gnt_vld, push_vld;
    logic [ID_W-1:0]           hi_idx, lo_idx, gnt_idx;
    logic [24:0]               sel_a;
    logic [17:0]               sel_b;

`ifdef DSP_ARB_ACC_EN
    logic                      burst_q, burst_d;
    logic [ID_W-1:0]           owner_q, owner_d;
    logic                      sel_acc, sel_last;
`else
    logic                      unused_acc;
    assign unused_acc = ^{req_acc, req_last};
`endif

    always_comb begin
        // Eligibility: nothing before the first post-reset clock, and only
        // the burst owner while an accumulate burst is open.
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = ce_q;
`ifdef DSP_ARB_ACC_EN
            if (burst_q && owner_q != ID_W'(i)) elig[i] = 1'b0;
`endif
        end

        // Rotating priority: lowest candidate at/above the pointer wins,
        // otherwise wrap to the lowest candidate overall. Descending scan
        // leaves the lowest index in each result.
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req_valid[i] && elig[i]) begin
                if (ID_W'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = ID_W'(i);
                end
                lo_vld = 1'b1;
                lo_idx = ID_W'(i);
            end
        end
        gnt_vld = hi_vld | lo_vld;
        gnt_idx = hi_vld ? hi_idx : lo_idx;

        sel_a = '0;
        sel_b = '0;
`ifdef DSP_ARB_ACC_EN
        sel_acc  = 1'b0;
        sel_last = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = gnt_vld && (gnt_idx == ID_W'(i));
            if (req_ready[i]) begin
                sel_a = req_a[25*i +: 25];
                sel_b = req_b[18*i +: 18];
`ifdef DSP_ARB_ACC_EN
                sel_acc  = req_acc[i];
                sel_last = req_last[i];
`endif
            end
        end

        ptr_d = ptr_q;
        if (gnt_vld) ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

        // Operands hold on idle cycles; only the opmode changes.
        dsp_a_d  = dsp_a_q;
        dsp_b_d  = dsp_b_q;
        op_iss_d = OP_IDLE;
        push_vld = 1'b0;
        if (gnt_vld) begin
            dsp_a_d  = {{5{sel_a[24]}}, sel_a};
            dsp_b_d  = sel_b;
            op_iss_d = OP_MUL;
            push_vld = 1'b1;
        end

`ifdef DSP_ARB_ACC_EN
        burst_d = burst_q;
        owner_d = owner_q;
        // An idle gap inside a burst must keep the partial sum in P.
        if (burst_q && !gnt_vld) op_iss_d = OP_HOLD;
        if (gnt_vld && sel_acc) begin
            op_iss_d = burst_q ? OP_MAC : OP_MUL;
            push_vld = sel_last;   // only the closing beat produces a response
            burst_d  = !sel_last;
            owner_d  = gnt_idx;
        end
`endif

        vld_pipe_d = {vld_pipe_q[DSP_LAT-1:0], push_vld};
        id_pipe_d  = {id_pipe_q[DSP_LAT-1:0], gnt_idx};

        rsp_valid_d = vld_pipe_q[DSP_LAT];
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (vld_pipe_q[DSP_LAT]) begin
            rsp_id_d   = id_pipe_q[DSP_LAT];
            rsp_data_d = dsp_p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q         <= 1'b0;
            ptr_q        <= '0;
            dsp_a_q      <= '0;
            dsp_b_q      <= '0;
            op_iss_q     <= '0;
            dsp_opmode_q <= '0;
            vld_pipe_q   <= '0;
            id_pipe_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            ce_q         <= 1'b1;
            ptr_q        <= ptr_d;
            dsp_a_q      <= dsp_a_d;
            dsp_b_q      <= dsp_b_d;
            op_iss_q     <= op_iss_d;
            // Extra stage so OPMODEREG sees the opmode when MREG holds M.
            dsp_opmode_q <= op_iss_q;
            vld_pipe_q   <= vld_pipe_d;
            id_pipe_q    <= id_pipe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

`ifdef DSP_ARB_ACC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= 1'b0;
            owner_q <= '0;
        end else begin
            burst_q <= burst_d;
            owner_q <= owner_d;
        end
    end
    assign busy = (|vld_pipe_q) | burst_q;
`else
    assign busy = |vld_pipe_q;
`endif

    assign dsp_a       = dsp_a_q;
    assign dsp_b       = dsp_b_q;
    assign dsp_opmode  = dsp_opmode_q;
    assign dsp_alumode = 4'b0000;
    assign dsp_inmode  = 5'b00000;
    assign dsp_ce      = ce_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;

endmodule
